// File: rtl/uart_rx_core.sv
// uart_rx_core -- oversampling UART receiver with sticky status flags.
//
// Purpose:
//   Receives asynchronous serial frames on RXD: a start bit, DATA_BITS data
//   bits (LSB first), an optional parity bit and STOP_BITS stop bits. Each bit
//   is OVS clk cycles long. Every bit after the start bit is decided by a
//   majority vote over all of its OVS samples. A completed word is presented
//   on RX_DATA together with a sticky "word available" flag and sticky error
//   bits. The consumer clears the flag and the error bits with an acknowledge.
//
// Ports:
//   clk                  in   sole clock, rising edge
//   reset_n              in   asynchronous active-low reset
//   RXD                  in   serial line, idle high, asynchronous to clk
//   rx_complete_del_flag in   acknowledge: clears the flag and all error bits
//   RX_DATA              out  last received word, LSB = first data bit
//   rx_complete_flag     out  sticky "word available"
//   parity_err           out  sticky parity mismatch in the last word
//   frame_err            out  sticky: a stop bit was decided 0
//   overrun_err          out  sticky: a word completed while the flag was set
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 RXD,
  input  logic                 rx_complete_del_flag,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 rx_complete_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(OVS);      // cycle-in-bit counter width
  localparam int AW = $clog2(OVS) + 1;  // ones accumulator must hold OVS itself
  localparam int IW = 4;                // bit index: up to 9 data bits

  localparam logic [CW-1:0] CNT_LAST      = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_MID       = CW'(OVS / 2 - 1);
  localparam logic [AW-1:0] ONES_HALF     = AW'(OVS / 2);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS_ST,
    PARITY_BIT,
    STOP_BIT
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer. Resetting to 1 (idle line) means a reset can
  // never create a phantom falling edge.
  // ---------------------------------------------------------------------
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          ones_q, ones_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_pend_q, par_pend_d;
  logic                   frm_pend_q, frm_pend_d;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   flag_q, flag_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   ovr_err_q, ovr_err_d;

  // Intermediate decode
  logic                   bit_end;
  logic [AW-1:0]          ones_sum;
  logic                   bit_val;
  logic                   exp_par;
  logic                   complete;
  logic                   par_now;
  logic                   frm_now;

  // The decision includes the sample of the bit's final cycle, so the vote
  // is over all OVS samples even though the accumulator only holds OVS-1.
  assign bit_end  = (cnt_q == CNT_LAST);
  assign ones_sum = ones_q + AW'(rxs_q);
  assign bit_val  = (ones_sum >= ONES_HALF);
  assign exp_par  = (^shift_q) ^ (PARITY_ODD != 0);

  // ---------------------------------------------------------------------
  // FSM next state, counters and data capture
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    complete   = 1'b0;
    par_now    = par_pend_q;
    frm_now    = frm_pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        ones_d = '0;
        idx_d  = '0;
        if (!rxs_q) begin
          state_d    = START_BIT;
          par_pend_d = 1'b0;
          frm_pend_d = 1'b0;
        end
      end

      START_BIT: begin
        ones_d = '0;
        if (cnt_q == CNT_MID && rxs_q) begin
          // Line back high at mid start bit: glitch, not a frame.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d = DATA_BITS_ST;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA_BITS_ST: begin
        if (bit_end) begin
          cnt_d  = '0;
          ones_d = '0;
          // Shift in from the top: after DATA_BITS bits the first bit
          // received sits in the LSB.
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY_BIT : STOP_BIT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          ones_d = ones_sum;
        end
      end

      PARITY_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          ones_d  = '0;
          idx_d   = '0;
          state_d = STOP_BIT;
          if (bit_val != exp_par) begin
            par_pend_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          ones_d = ones_sum;
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          cnt_d  = '0;
          ones_d = '0;
          if (idx_q == IDX_STOP_LAST) begin
            // Last stop bit: hand the word and its errors to the outputs
            // on this edge; pending state is consumed.
            complete   = 1'b1;
            frm_now    = frm_pend_q | ~bit_val;
            state_d    = IDLE;
            idx_d      = '0;
            par_pend_d = 1'b0;
            frm_pend_d = 1'b0;
          end else begin
            frm_pend_d = frm_pend_q | ~bit_val;
            idx_d      = idx_q + IW'(1);
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          ones_d = ones_sum;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / status registers
  // ---------------------------------------------------------------------
  always_comb begin
    rx_data_d = rx_data_q;
    flag_d    = flag_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    ovr_err_d = ovr_err_q;

    if (complete) begin
      rx_data_d = shift_q;
      flag_d    = 1'b1;
      if (rx_complete_del_flag) begin
        // Acknowledge lands together with a new word: the old status is
        // consumed, only the new word's errors remain, no overrun.
        par_err_d = par_now;
        frm_err_d = frm_now;
        ovr_err_d = 1'b0;
      end else begin
        par_err_d = par_err_q | par_now;
        frm_err_d = frm_err_q | frm_now;
        ovr_err_d = ovr_err_q | flag_q;
      end
    end else if (rx_complete_del_flag) begin
      flag_d    = 1'b0;
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
      ovr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ones_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      rx_data_q  <= '0;
      flag_q     <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      rx_data_q  <= rx_data_d;
      flag_q     <= flag_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign RX_DATA          = rx_data_q;
  assign rx_complete_flag = flag_q;
  assign parity_err       = par_err_q;
  assign frame_err        = frm_err_q;
  assign overrun_err      = ovr_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- self-checking bench for uart_rx_core.
//
// Three receivers share clk and reset_n:
//   inst 0: defaults (8 data bits, no parity, 1 stop bit)
//   inst 1: 7 data bits, odd parity
//   inst 2: 8 data bits, 2 stop bits
// Expected words are pushed to a scoreboard queue when a frame is driven
// and popped when the receiver reports completion.
module tb_uart_rx_core;

  localparam int OVS = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       flag;
    logic       par;
    logic       frm;
    logic       ovr;
  } exp_t;

  logic clk;
  logic reset_n;

  logic       rxd0, del0, f0, p0, fr0, o0;
  logic [7:0] d0;
  logic       rxd1, del1, f1, p1, fr1, o1;
  logic [6:0] d1;
  logic       rxd2, del2, f2, p2, fr2, o2;
  logic [7:0] d2;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  uart_rx_core u_dut0 (
    .clk(clk), .reset_n(reset_n), .RXD(rxd0), .rx_complete_del_flag(del0),
    .RX_DATA(d0), .rx_complete_flag(f0), .parity_err(p0), .frame_err(fr0),
    .overrun_err(o0)
  );

  uart_rx_core #(.DATA_BITS(7), .OVS(OVS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .RXD(rxd1), .rx_complete_del_flag(del1),
    .RX_DATA(d1), .rx_complete_flag(f1), .parity_err(p1), .frame_err(fr1),
    .overrun_err(o1)
  );

  uart_rx_core #(.DATA_BITS(8), .OVS(OVS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .RXD(rxd2), .rx_complete_del_flag(del2),
    .RX_DATA(d2), .rx_complete_flag(f2), .parity_err(p2), .frame_err(fr2),
    .overrun_err(o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [8:0] data, input logic flag,
                              input logic par, input logic frm, input logic ovr);
    exp_t e;
    e.data = data;
    e.flag = flag;
    e.par  = par;
    e.frm  = frm;
    e.ovr  = ovr;
    return e;
  endfunction

  function automatic exp_t obs(input int inst);
    exp_t o;
    case (inst)
      0:       o = mk({1'b0, d0}, f0, p0, fr0, o0);
      1:       o = mk({2'b0, d1}, f1, p1, fr1, o1);
      default: o = mk({1'b0, d2}, f2, p2, fr2, o2);
    endcase
    return o;
  endfunction

  task automatic set_rxd(input int inst, input logic v);
    case (inst)
      0:       rxd0 = v;
      1:       rxd1 = v;
      default: rxd2 = v;
    endcase
  endtask

  task automatic set_del(input int inst, input logic v);
    case (inst)
      0:       del0 = v;
      1:       del1 = v;
      default: del2 = v;
    endcase
  endtask

  // Drives n bits (bits[0] first), OVS cycles each, forcing the line low for
  // cycles [g_start, g_start+g_len) of the frame. Called and returns on a
  // negedge; leaves the line idle.
  task automatic send_bits(input int inst, input logic [15:0] bits, input int n,
                           input int g_start, input int g_len);
    logic [15:0] cur;
    logic        v;
    cur = bits;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < OVS; k++) begin
        v = cur[0];
        if ((b * OVS + k) >= g_start && (b * OVS + k) < g_start + g_len) v = 1'b0;
        set_rxd(inst, v);
        @(negedge clk);
      end
      cur = cur >> 1;
    end
    set_rxd(inst, 1'b1);
  endtask

  task automatic wait_flag(input int inst, output bit ok);
    exp_t o;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      o = obs(inst);
      if (o.flag === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack(input int inst);
    set_del(inst, 1'b1);
    @(negedge clk);
    set_del(inst, 1'b0);
  endtask

  task automatic test_reset();
    exp_t got;
    reset_n = 1'b0;
    rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
    del0 = 1'b0; del1 = 1'b0; del2 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = obs(i);
      total++;
      if (got !== mk(9'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_state inst=%0d: got=%h exp=%h", i, got, mk(9'h0, 0, 0, 0, 0));
      end
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t got, e;
    sb.push_back(mk(9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0));
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1, 0);
    repeat (2) @(negedge clk);           // inside the last stop-bit cycle
    got = obs(0);
    total++;
    if (got.flag !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: flag=%b exp=0", got.flag);
    end
    @(negedge clk);                      // one cycle after the last stop cycle
    got = obs(0);
    e = sb.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL basic_a5: got=%h exp=%h", got, e);
    end
    $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    ack(0);
    got = obs(0);
    total++;
    if (got !== mk(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL basic_ack: got=%h exp=%h", got, mk(9'h0A5, 0, 0, 0, 0));
    end
  endtask

  task automatic test_parity();
    exp_t got, e;
    bit ok;
    logic [6:0] d;
    logic good_p;
    // Wrong parity bit on 0x55.
    d = 7'h55;
    good_p = (^d) ^ 1'b1;
    sb.push_back(mk({2'b0, d}, 1'b1, 1'b1, 1'b0, 1'b0));
    send_bits(1, 16'({1'b1, ~good_p, d, 1'b0}), 10, -1, 0);
    wait_flag(1, ok);
    got = obs(1);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL parity_bad: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=1 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    ack(1);
    // Correct parity bit on 0x23.
    d = 7'h23;
    good_p = (^d) ^ 1'b1;
    sb.push_back(mk({2'b0, d}, 1'b1, 1'b0, 1'b0, 1'b0));
    send_bits(1, 16'({1'b1, good_p, d, 1'b0}), 10, -1, 0);
    wait_flag(1, ok);
    got = obs(1);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL parity_good: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=1 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    ack(1);
  endtask

  task automatic test_glitch();
    exp_t got, e;
    bit ok;
    // Short low pulse while idle must not start a frame.
    rxd0 = 1'b0;
    repeat (5) @(negedge clk);
    rxd0 = 1'b1;
    repeat (3 * OVS) @(negedge clk);
    got = obs(0);
    total++;
    if (got !== mk(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL idle_glitch: got=%h exp=%h", got, mk(9'h0A5, 0, 0, 0, 0));
    end
    // 8 low cycles inside data bit 1 of 0xFF: vote still 1.
    sb.push_back(mk(9'h0FF, 1'b1, 1'b0, 1'b0, 1'b0));
    send_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10, 2 * OVS + 4, 8);
    wait_flag(0, ok);
    got = obs(0);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL glitch8: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    ack(0);
    // 9 low cycles: vote flips to 0.
    sb.push_back(mk(9'h0FD, 1'b1, 1'b0, 1'b0, 1'b0));
    send_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10, 2 * OVS + 4, 9);
    wait_flag(0, ok);
    got = obs(0);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL glitch9: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    // Left unacknowledged on purpose: the reset test needs live outputs.
  endtask

  task automatic test_reset_mid();
    exp_t got, e;
    bit ok;
    // Start bit and data bits 0..2 of 0x3C, then into bit 3 (a 1).
    send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 4, -1, 0);
    rxd0 = 1'b1;
    repeat (OVS / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    got = obs(0);
    total++;
    if (got !== mk(9'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_async: got=%h exp=%h", got, mk(9'h0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    got = obs(0);
    total++;
    if (got !== mk(9'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_discard: got=%h exp=%h", got, mk(9'h0, 0, 0, 0, 0));
    end
    sb.push_back(mk(9'h03C, 1'b1, 1'b0, 1'b0, 1'b0));
    send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1, 0);
    wait_flag(0, ok);
    got = obs(0);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL reset_next_3c: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    ack(0);
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    bit ok;
    sb.push_back(mk(9'h012, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(9'h034, 1'b1, 1'b0, 1'b0, 1'b1));
    fork
      begin
        send_bits(0, 16'({1'b1, 8'h12, 1'b0}), 10, -1, 0);
        send_bits(0, 16'({1'b1, 8'h34, 1'b0}), 10, -1, 0);
      end
      begin
        wait_flag(0, ok);
        got = obs(0);
        e = sb.pop_front();
        total++;
        if (!ok || got !== e) begin
          bad++;
          $display("FAIL b2b_first: got=%h exp=%h done=%b", got, e, ok);
        end
        $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (d0 !== 8'h12) begin
            ok = 1'b1;
            break;
          end
        end
        got = obs(0);
        e = sb.pop_front();
        total++;
        if (!ok || got !== e) begin
          bad++;
          $display("FAIL b2b_overrun: got=%h exp=%h done=%b", got, e, ok);
        end
        $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
      end
    join
    repeat (4) @(negedge clk);
    ack(0);
    got = obs(0);
    total++;
    if (got !== mk(9'h034, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL b2b_ack: got=%h exp=%h", got, mk(9'h034, 0, 0, 0, 0));
    end
  endtask

  task automatic test_break();
    exp_t got, e;
    bit ok;
    sb.push_back(mk(9'h000, 1'b1, 1'b0, 1'b1, 1'b0));
    send_bits(0, 16'h0000, 10, -1, 0);
    wait_flag(0, ok);
    got = obs(0);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL break: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=0 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    ack(0);
    repeat (3 * OVS) @(negedge clk);
    got = obs(0);
    total++;
    if (got !== mk(9'h000, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL break_idle: got=%h exp=%h", got, mk(9'h0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_stop2();
    exp_t got, e;
    bit ok;
    sb.push_back(mk(9'h011, 1'b1, 1'b0, 1'b0, 1'b0));
    send_bits(2, 16'({2'b11, 8'h11, 1'b0}), 11, -1, 0);
    wait_flag(2, ok);
    got = obs(2);
    e = sb.pop_front();
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL stop2_good: got=%h exp=%h done=%b", got, e, ok);
    end
    $display("tb: inst=2 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
    // Flag still set; second stop bit low; acknowledge lands on completion.
    sb.push_back(mk(9'h05A, 1'b1, 1'b0, 1'b1, 1'b0));
    send_bits(2, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11, -1, 0);
    repeat (2) @(negedge clk);
    del2 = 1'b1;
    @(negedge clk);
    del2 = 1'b0;
    got = obs(2);
    e = sb.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL stop2_del_coincide: got=%h exp=%h", got, e);
    end
    $display("tb: inst=2 word=%h flag=%b err=%b%b%b", got.data, got.flag, got.par, got.frm, got.ovr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_break();
    test_stop2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time=%0t limit=1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have these parameters:
  - DATA_BITS, default 8, data bits per frame, legal range 5..9.
  - OVS, default 16, clk cycles per bit, even, 4..64.
  - PARITY_EN, default 0, 1 = parity bit present after the data bits.
  - PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
  - STOP_BITS, default 1, number of stop bits, 1 or 2.
REQ-002 The block SHALL have these ports:
  - clk  in  1  sole clock; all logic on the rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
  - RXD  in  1  serial line, idle high, asynchronous to clk.
  - rx_complete_del_flag  in  1  consumer acknowledge; clears the flag and all error bits.
  - RX_DATA  out  DATA_BITS  last received word, LSB = first data bit received.
  - rx_complete_flag  out  1  sticky "word available".
  - parity_err  out  1  sticky; parity mismatch in the last word.
  - frame_err  out  1  sticky; a stop bit sampled as 0 in the last word.
  - overrun_err  out  1  sticky; a word completed while rx_complete_flag was still 1.

Function
REQ-003 RXD SHALL pass through a 2-flop synchronizer (flops reset to 1); all logic below uses the synchronized value rxs.
REQ-004 The FSM SHALL have states IDLE, START_BIT, DATA_BITS_ST, PARITY_BIT, STOP_BIT; encoding is free.
REQ-005 IDLE: on rxs=0 the FSM SHALL go to START_BIT with the bit counter at 0; otherwise it stays in IDLE.
REQ-006 START_BIT: the bit counter SHALL count 0..OVS-1.
  - At count OVS/2-1, rxs=1 SHALL abort to IDLE (false start) with no output change.
  - At count OVS-1 the FSM SHALL go to DATA_BITS_ST with bit index 0.
REQ-007 Each data, parity and stop bit SHALL last exactly OVS cycles; a ones-accumulator of width clog2(OVS)+1 sums rxs over those cycles.
REQ-008 The bit decision SHALL be 1 when ones >= OVS/2, else 0; the accumulator SHALL clear at the start of every bit.
REQ-009 DATA_BITS_ST SHALL store each decided bit at the current bit index (LSB first) in an internal shift/hold register.
  - After bit index DATA_BITS-1, the next state SHALL be PARITY_BIT if PARITY_EN=1, else STOP_BIT.
REQ-010 PARITY_BIT: expected parity = XOR of data bits, inverted when PARITY_ODD=1; a mismatch with the decided bit SHALL set an internal pending parity-error bit.
REQ-011 STOP_BIT SHALL be sampled STOP_BITS times; any stop bit decided 0 SHALL set an internal pending frame-error bit.
REQ-012 Completion (final cycle of the last stop bit) SHALL, in the next cycle:
  - load RX_DATA;
  - set rx_complete_flag=1;
  - OR the pending parity and frame errors into parity_err and frame_err;
  - return the FSM to IDLE.
  Latency: the flag is high exactly 1 cycle after the last stop-bit cycle.
REQ-013 A word SHALL be delivered even when frame_err or parity_err is set; RX_DATA holds its value between completions.
REQ-014 If completion occurs while rx_complete_flag=1 and rx_complete_del_flag=0, RX_DATA SHALL be overwritten and overrun_err set to 1.
REQ-015 rx_complete_del_flag=1 with no completion in the same cycle SHALL clear rx_complete_flag, parity_err, frame_err and overrun_err next cycle; reception in progress is unaffected.
REQ-016 When completion and rx_complete_del_flag=1 coincide:
  - rx_complete_flag SHALL be 1;
  - old error bits SHALL clear;
  - only the new word's errors SHALL be set;
  - overrun_err SHALL be 0.
REQ-017 After completion the FSM SHALL accept a new start bit from the first IDLE cycle (back-to-back frames, no extra idle bit required).
REQ-018 A line held low through a whole frame SHALL yield RX_DATA=0 and frame_err=1, then restart from IDLE.

Reset
REQ-019 reset_n=0 SHALL asynchronously force:
  - FSM to IDLE;
  - counters, accumulator and pending errors to 0;
  - RX_DATA=0, rx_complete_flag=0, parity_err=0, frame_err=0, overrun_err=0;
  - synchronizer flops to 1.
REQ-020 Reset mid-frame SHALL discard the partial word; after release the block SHALL wait for a fresh falling edge on rxs.

Verification
REQ-021 Defaults: frame 0xA5, 16 clk/bit, 1 stop bit -> RX_DATA=0xA5, flag=1 exactly 1 cycle after the last stop cycle, all errors 0.
REQ-022 DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1: send 0x55 with a wrong parity bit -> RX_DATA=0x55, parity_err=1, frame_err=0.
REQ-023 Low glitch of 5 cycles in IDLE -> no completion and FSM back in IDLE; an 8-cycle glitch during the data bit holding 1 of 0xFF -> RX_DATA=0xFF (majority vote).
REQ-024 Two frames 0x12, 0x34 with no acknowledge -> RX_DATA=0x34, overrun_err=1; a del pulse then clears flag and all errors.
REQ-025 STOP_BITS=2 with the second stop bit low -> frame_err=1; a del pulse in the completion cycle -> flag=1, overrun_err=0.
REQ-026 reset_n pulsed low at data bit 3 -> all outputs 0 immediately; the next full frame 0x3C is received correctly.
